fifo_access_sched: RTL and testbench

Scheduler/arbiter in front of the 4-bit async-style FIFO (tt_um_reemashivva_fifo datapath).
- Replaces derived w_clk/r_clk with single-clock enable ticks.
- Round-robin shares the FIFO write port between two producers.
- Sequences consumer reads with a req/valid/ack handshake.
- Sits between producer/consumer logic and the FIFO's write/read ports on the same clk.

---
 rtl/fifo_sched_pkg.sv | 14 +
 rtl/fifo_access_sched_tick_gen.sv | 28 ++
 rtl/fifo_access_sched.sv | 153 +++++++++++++++
 tb/tb_fifo_access_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO access scheduler.
// Read-handshake state encoding, default data width and stall-counter width.
package fifo_sched_pkg;

    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned STALL_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        VALID
    } rd_state_e;

endpackage

// File: rtl/fifo_access_sched_tick_gen.sv
// Free-running modulo-DIV counter; tick_o is high on the last count of each period.
// Replaces the divided write/read clocks of the original FIFO wrapper.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_access_sched.sv
// Single-clock scheduler in front of the 4-bit FIFO: round-robin write port sharing
// between two producers and a req/valid/ack sequenced read path, both paced by tick enables.
module fifo_access_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned WR_DIV = 4,
    parameter int unsigned RD_DIV = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [WIDTH-1:0]       data0,
    input  logic                   req1,
    input  logic [WIDTH-1:0]       data1,
    output logic                   gnt0,
    output logic                   gnt1,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   fifo_rd_en,
    input  logic [WIDTH-1:0]       fifo_rdata,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    input  logic                   rd_ack,
    output logic [STALL_CNT_W-1:0] wr_stall_cnt
);

    logic wr_tick;
    logic rd_tick;

    tick_gen #(.DIV(WR_DIV)) u_wr_tick (
        .clk_i  (clk),
        .reset_i(reset),
        .tick_o (wr_tick)
    );

    tick_gen #(.DIV(RD_DIV)) u_rd_tick (
        .clk_i  (clk),
        .reset_i(reset),
        .tick_o (rd_tick)
    );

    // ---------------- write arbiter ----------------
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   wr_en_q, wr_en_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   last1_q, last1_d;  // 1: producer 1 won most recently
    logic                   eff0, eff1;

    // A producer whose grant is showing this cycle has not yet had a chance to drop req.
    assign eff0 = req0 & ~gnt0_q;
    assign eff1 = req1 & ~gnt1_q;

    always_comb begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        wr_en_d = 1'b0;
        wdata_d = '0;
        stall_d = stall_q;
        last1_d = last1_q;
        if (wr_tick && (eff0 || eff1)) begin
            if (fifo_full) begin
                if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
            end else if (eff0 && (!eff1 || last1_q)) begin
                gnt0_d  = 1'b1;
                wr_en_d = 1'b1;
                wdata_d = data0;
                last1_d = 1'b0;
            end else begin
                gnt1_d  = 1'b1;
                wr_en_d = 1'b1;
                wdata_d = data1;
                last1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            stall_q <= '0;
            last1_q <= 1'b1;
        end else begin
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            stall_q <= stall_d;
            last1_q <= last1_d;
        end
    end

    // ---------------- read sequencer ----------------
    rd_state_e        rd_state_q;
    logic             rd_en_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= IDLE;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (rd_state_q)
                IDLE: begin
                    if (rd_tick && rd_req && !fifo_empty) begin
                        rd_state_q <= ISSUE;
                        rd_en_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    rd_en_q    <= 1'b0;
                    rd_data_q  <= fifo_rdata;
                    rd_valid_q <= 1'b1;
                    rd_state_q <= VALID;
                end
                VALID: begin
                    if (rd_ack) begin
                        rd_valid_q <= 1'b0;
                        rd_state_q <= IDLE;
                    end
                end
                default: begin
                    rd_en_q    <= 1'b0;
                    rd_valid_q <= 1'b0;
                    rd_state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wdata   = wdata_q;
    assign wr_stall_cnt = stall_q;
    assign fifo_rd_en   = rd_en_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_fifo_access_sched.sv
// Scoreboard bench for fifo_access_sched: stimulus queues expected writes, reads and
// point checks; a negedge monitor pops and compares whatever the DUT presents.
module tb_fifo_access_sched;
    import fifo_sched_pkg::*;

    localparam int CK_ZERO    = 0;
    localparam int CK_STALL   = 1;
    localparam int CK_RD_IDLE = 2;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       g1;
    } wr_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        int         fall;
    } rd_exp_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } pt_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1;
    logic       fifo_full = 1'b0, fifo_empty = 1'b1;
    logic       fifo_wr_en, fifo_rd_en;
    logic [3:0] fifo_wdata, fifo_rdata = '0;
    logic       rd_req = 1'b0, rd_ack = 1'b0;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [7:0] wr_stall_cnt;

    fifo_access_sched #(
        .WIDTH (4),
        .WR_DIV(4),
        .RD_DIV(6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .data0       (data0),
        .req1        (req1),
        .data1       (data1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wdata  (fifo_wdata),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rdata  (fifo_rdata),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .wr_stall_cnt(wr_stall_cnt)
    );

    always #5 clk = ~clk;

    int edges = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    wr_exp_t wq[$];
    int      rq[$];
    rd_exp_t vq[$];
    pt_exp_t dq[$];

    // ---------------- monitor / scoreboard ----------------
    int          c;
    wr_exp_t     we;
    int          re;
    rd_exp_t     cur;
    pt_exp_t     pe;
    logic        have_cur = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] act;

    always @(negedge clk) begin
        c = edges - base;
        if (fifo_wr_en || gnt0 || gnt1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: cycle %0d wr_en=%b wdata=%h gnt0=%b gnt1=%b, required no write",
                         c, fifo_wr_en, fifo_wdata, gnt0, gnt1);
            end else begin
                we = wq.pop_front();
                if (!(c == we.cyc && fifo_wr_en && fifo_wdata == we.data &&
                      gnt0 == !we.g1 && gnt1 == we.g1)) begin
                    errors++;
                    $display("FAIL write: got cycle %0d wr_en=%b wdata=%h gnt0=%b gnt1=%b, required cycle %0d wr_en=1 wdata=%h gnt0=%b gnt1=%b",
                             c, fifo_wr_en, fifo_wdata, gnt0, gnt1, we.cyc, we.data, !we.g1, we.g1);
                end
            end
        end
        if (fifo_rd_en) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_en: cycle %0d, required no pop", c);
            end else begin
                re = rq.pop_front();
                if (c != re) begin
                    errors++;
                    $display("FAIL rd_en_cycle: got %0d, required %0d", c, re);
                end
            end
        end
        if (rd_valid && !prev_valid) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid: cycle %0d rd_data=%h, required none", c, rd_data);
            end else begin
                cur = vq.pop_front();
                have_cur = 1'b1;
                if (c != cur.cyc || rd_data != cur.data) begin
                    errors++;
                    $display("FAIL rd_valid_start: got cycle %0d data %h, required cycle %0d data %h",
                             c, rd_data, cur.cyc, cur.data);
                end
            end
        end else if (rd_valid && have_cur) begin
            checks++;
            if (rd_data != cur.data) begin
                errors++;
                $display("FAIL rd_data_stable: cycle %0d got %h, required %h", c, rd_data, cur.data);
            end
        end else if (!rd_valid && prev_valid && have_cur) begin
            checks++;
            have_cur = 1'b0;
            if (c != cur.fall) begin
                errors++;
                $display("FAIL rd_valid_end: dropped at cycle %0d, required %0d", c, cur.fall);
            end
        end
        prev_valid = rd_valid;

        while (dq.size() > 0) begin
            pe = dq.pop_front();
            checks++;
            case (pe.kind)
                CK_ZERO:  act = 32'({fifo_wr_en, gnt0, gnt1, fifo_rd_en, rd_valid,
                                     rd_data, fifo_wdata, wr_stall_cnt});
                CK_STALL: act = 32'(wr_stall_cnt);
                default:  act = 32'({fifo_rd_en, rd_valid, dut.rd_state_q == IDLE});
            endcase
            if (act != pe.exp) begin
                errors++;
                $display("FAIL point_check kind %0d: cycle %0d got %h, required %h", pe.kind, c, act, pe.exp);
            end
        end

        if (done) begin
            checks++;
            if (wq.size() != 0 || rq.size() != 0 || vq.size() != 0) begin
                errors++;
                $display("FAIL missing_events: writes %0d pops %0d valids %0d outstanding, required 0 0 0",
                         wq.size(), rq.size(), vq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic at(input int k);
        while (edges - base < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_rst();
        reset = 1'b0;
        base = edges;
    endtask

    task automatic push_wr(input int cy, input logic [3:0] d, input logic g1);
        wr_exp_t e;
        e.cyc = cy; e.data = d; e.g1 = g1;
        wq.push_back(e);
    endtask

    task automatic push_rd(input int cy, input logic [3:0] d, input int fall);
        rd_exp_t e;
        rq.push_back(cy - 1);
        e.cyc = cy; e.data = d; e.fall = fall;
        vq.push_back(e);
    endtask

    task automatic push_pt(input int kind, input logic [31:0] exp);
        pt_exp_t e;
        e.kind = kind; e.exp = exp;
        dq.push_back(e);
    endtask

    initial begin
        // 1: reset outputs, first single-producer write
        repeat (3) begin
            @(posedge clk);
            #1;
            push_pt(CK_ZERO, 32'h0);
        end
        req0 = 1'b1; data0 = 4'hA;
        release_rst();
        push_wr(4, 4'hA, 1'b0);
        at(5);  req0 = 1'b0;
        at(10);

        // 2: both producers, round-robin alternation
        do_reset(2);
        req0 = 1'b1; data0 = 4'hA; req1 = 1'b1; data1 = 4'h5;
        release_rst();
        push_wr(4, 4'hA, 1'b0);
        push_wr(8, 4'h5, 1'b1);
        push_wr(12, 4'hA, 1'b0);
        push_wr(16, 4'h5, 1'b1);
        at(17); req0 = 1'b0; req1 = 1'b0;
        at(21);

        // 3: full FIFO stalls three ticks, then write after clearing
        do_reset(2);
        req0 = 1'b1; data0 = 4'h3; fifo_full = 1'b1;
        release_rst();
        push_wr(16, 4'h3, 1'b0);
        at(8);  push_pt(CK_STALL, 32'd2);
        at(12); push_pt(CK_STALL, 32'd3); fifo_full = 1'b0;
        at(17); req0 = 1'b0;
        at(21); push_pt(CK_STALL, 32'd3);

        // 4: two reads; second one holds VALID across a skipped read tick
        do_reset(2);
        rd_req = 1'b1; fifo_empty = 1'b0; fifo_rdata = 4'h7;
        release_rst();
        push_rd(7, 4'h7, 11);
        push_rd(13, 4'h9, 20);
        at(10); rd_ack = 1'b1;
        at(11); rd_ack = 1'b0; fifo_rdata = 4'h9;
        at(19); rd_ack = 1'b1;
        at(20); rd_ack = 1'b0; rd_req = 1'b0;
        at(26); push_pt(CK_RD_IDLE, 32'h1);

        // 5: empty FIFO never popped
        do_reset(2);
        rd_req = 1'b1; fifo_empty = 1'b1;
        release_rst();
        at(20); push_pt(CK_RD_IDLE, 32'h1); rd_req = 1'b0;
        at(21);

        // 6: reset lands in VALID with a write decision on the same edge
        do_reset(2);
        req0 = 1'b1; data0 = 4'h6; rd_req = 1'b1; fifo_empty = 1'b0; fifo_rdata = 4'hC;
        release_rst();
        push_wr(4, 4'h6, 1'b0);
        push_rd(7, 4'hC, 8);
        at(5); req0 = 1'b0;
        at(7); req0 = 1'b1; data0 = 4'hE; reset = 1'b1;
        at(8); push_pt(CK_ZERO, 32'h0); push_pt(CK_RD_IDLE, 32'h1);
        at(9); req0 = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1;
        release_rst();
        at(14);
        done = 1'b1;
    end

endmodule
